// File: rtl/slot_reels.sv
// Three-reel counter: start spins all reels, each stop freezes the next one.
// valid marks the frozen result once all three reels have stopped.
module slot_reels #(
    parameter int WIDTH = 7,
    parameter int MAX   = 99,
    parameter int STEP1 = 1,
    parameter int STEP2 = 3,
    parameter int STEP3 = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] number1,
    output logic [WIDTH-1:0] number2,
    output logic [WIDTH-1:0] number3,
    output logic [2:0]       reel_run,
    output logic             spinning,
    output logic             valid
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RUN3 = 3'd1;
    localparam logic [2:0] RUN2 = 3'd2;
    localparam logic [2:0] RUN1 = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [WIDTH:0] LMAX = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0] LMOD = (WIDTH+1)'(MAX + 1);
    localparam logic [WIDTH:0] S1   = (WIDTH+1)'(STEP1);
    localparam logic [WIDTH:0] S2   = (WIDTH+1)'(STEP2);
    localparam logic [WIDTH:0] S3   = (WIDTH+1)'(STEP3);

    logic [2:0] state;
    logic [2:0] state_nx;
    logic [2:0] freeze;
    logic [2:0] adv;

    // Sum is one bit wider than the reel so the wrap compare cannot overflow.
    function automatic logic [WIDTH-1:0] bump(
        input logic [WIDTH-1:0] n,
        input logic [WIDTH:0]   step
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, n} + step;
        return WIDTH'((sum > LMAX) ? sum - LMOD : sum);
    endfunction

    always_comb begin
        state_nx = state;
        freeze   = 3'b000;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = RUN3;
            end
            RUN3: begin
                if (stop) begin
                    state_nx = RUN2;
                    freeze   = 3'b001;
                end
            end
            RUN2: begin
                if (stop) begin
                    state_nx = RUN1;
                    freeze   = 3'b010;
                end
            end
            RUN1: begin
                if (stop) begin
                    state_nx = DONE;
                    freeze   = 3'b100;
                end
            end
            DONE: begin
                if (start)
                    state_nx = RUN3;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        reel_run = 3'b000;
        unique case (state)
            RUN3:    reel_run = 3'b111;
            RUN2:    reel_run = 3'b110;
            RUN1:    reel_run = 3'b100;
            default: reel_run = 3'b000;
        endcase
    end

    assign adv      = reel_run & ~freeze;
    assign spinning = |reel_run;
    assign valid    = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            number1 <= '0;
            number2 <= '0;
            number3 <= '0;
        end else begin
            state <= state_nx;
            if (adv[0])
                number1 <= bump(number1, S1);
            if (adv[1])
                number2 <= bump(number2, S2);
            if (adv[2])
                number3 <= bump(number3, S3);
        end
    end

endmodule

// File: tb/tb_slot_reels.sv
// Bench for slot_reels: directed scenarios plus random start/stop traffic,
// checked against a reel-count model of the spin.
module tb_slot_reels;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [6:0] number1;
    logic [6:0] number2;
    logic [6:0] number3;
    logic [2:0] reel_run;
    logic       spinning;
    logic       valid;

    int compared   = 0;
    int mismatched = 0;

    int m_n[3];
    int m_steps[3] = '{1, 3, 7};
    int m_stopped;
    bit m_spin;
    bit m_done;

    slot_reels dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .number1  (number1),
        .number2  (number2),
        .number3  (number3),
        .reel_run (reel_run),
        .spinning (spinning),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_n[i] = 0;
        m_stopped = 0;
        m_spin    = 0;
        m_done    = 0;
    endtask

    // A spin is "reels stopped so far"; reel i runs while i >= that count.
    task automatic model_edge(input bit s, input bit p);
        if (!m_spin) begin
            if (s) begin
                m_spin    = 1;
                m_stopped = 0;
                m_done    = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++)
                if (i > m_stopped || (i == m_stopped && !p))
                    m_n[i] = (m_n[i] + m_steps[i]) % 100;
            if (p) begin
                m_stopped++;
                if (m_stopped == 3) begin
                    m_spin = 0;
                    m_done = 1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [2:0] er;
        for (int i = 0; i < 3; i++)
            er[i] = m_spin && (i >= m_stopped);
        chk({tag, "_n1"}, 32'(number1), 32'(m_n[0]));
        chk({tag, "_n2"}, 32'(number2), 32'(m_n[1]));
        chk({tag, "_n3"}, 32'(number3), 32'(m_n[2]));
        chk({tag, "_run"}, 32'(reel_run), 32'(er));
        chk({tag, "_spin"}, 32'(spinning), 32'(m_spin));
        chk({tag, "_valid"}, 32'(valid), 32'(m_done));
        chk({tag, "_range"},
            32'(number1 <= 99 && number2 <= 99 && number3 <= 99), 32'd1);
    endtask

    task automatic cyc(input string tag, input bit s, input bit p);
        start = s;
        stop  = p;
        @(posedge clk);
        model_edge(s, p);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        rst = 1'b0;

        cyc("t1_go", 1, 0);
        repeat (3) cyc("t1_run", 0, 0);
        chk("t1_pre_rst", 32'(reel_run), 32'd7);
        do_reset("t1_rst");
        chk("t1_rst_n3", 32'(number3), 32'd0);
        cyc("t1_stop_idle", 0, 1);
        cyc("t1_stop_idle", 0, 1);

        cyc("t2_go", 1, 0);
        chk("t2_go_n1", 32'(number1), 32'd0);
        repeat (5) cyc("t2_run", 0, 0);
        chk("t2_n1", 32'(number1), 32'd5);
        chk("t2_n2", 32'(number2), 32'd15);
        chk("t2_n3", 32'(number3), 32'd35);
        chk("t2_run", 32'(reel_run), 32'd7);

        cyc("t3_stop", 0, 1);
        chk("t3_n1", 32'(number1), 32'd5);
        chk("t3_n2", 32'(number2), 32'd18);
        chk("t3_n3", 32'(number3), 32'd42);
        chk("t3_run", 32'(reel_run), 32'd6);

        do_reset("t4_rst");
        cyc("t4_go", 1, 0);
        repeat (14) cyc("t4_run", 0, 0);
        chk("t4_n3_98", 32'(number3), 32'd98);
        cyc("t4_wrap3", 0, 0);
        chk("t4_n3_5", 32'(number3), 32'd5);
        repeat (84) cyc("t4_run", 0, 0);
        chk("t4_n1_99", 32'(number1), 32'd99);
        cyc("t4_wrap1", 0, 0);
        chk("t4_n1_0", 32'(number1), 32'd0);

        cyc("t5_s1", 0, 1);
        cyc("t5_s2", 0, 1);
        chk("t5_valid_lo", 32'(valid), 32'd0);
        cyc("t5_s3", 0, 1);
        chk("t5_valid_hi", 32'(valid), 32'd1);
        repeat (20) cyc("t5_hold", 0, 0);
        chk("t5_equal",
            32'(number1 == number2 && number2 == number3),
            32'(m_n[0] == m_n[1] && m_n[1] == m_n[2]));
        cyc("t6_stop_done", 0, 1);

        cyc("t6_both", 1, 1);
        chk("t6_valid", 32'(valid), 32'd0);
        chk("t6_run", 32'(reel_run), 32'd7);
        cyc("t6_adv", 0, 0);

        // Random traffic; values are chosen to make equal reels reachable.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 149) == 0)
                do_reset("rnd_rst");
            else
                cyc("rnd", $urandom_range(0, 7) == 0,
                    $urandom_range(0, 4) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
